// File: rtl/mem_wb_stage_if.sv
// Half-word SRAM bus between the memory stage (master) and the external SRAM (slave).
interface mem_wb_stage_if #(
  parameter int unsigned SRAM_AW = 18
) ();
  logic [SRAM_AW-1:0] sram_addr;
  logic [15:0]        sram_wdata;
  logic [15:0]        sram_rdata;
  logic               sram_we_n;
  logic               sram_oe_n;

  modport master (
    output sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    input  sram_rdata
  );

  modport slave (
    input  sram_addr, sram_wdata, sram_we_n, sram_oe_n,
    output sram_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory stage + MEM/WB register: 32-bit loads/stores as two half-word SRAM transfers.
// Define MEM_ADDR_CHECK_EN to add address checking and the sticky mem_err output.
module mem_wb_stage #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_en_in,
  input  logic           mem_r_en,
  input  logic           mem_w_en,
  input  logic [31:0]    alu_res,
  input  logic [31:0]    st_val,
  input  logic [3:0]     dest,
  output logic           freeze,
  mem_wb_stage_if.master sram,
  output logic           writeBackEn,
  output logic [3:0]     Dest_wb,
  output logic [31:0]    Result_WB
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic           mem_err
`endif
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  logic [3:0]         wait_cnt;
  logic [31:0]        rd_word;
  logic               req;
  logic               fault;
  logic               fault_q;
  logic [SRAM_AW-1:0] lo_addr;
  logic [SRAM_AW-1:0] hi_addr;

  assign req     = mem_r_en | mem_w_en;
  assign lo_addr = SRAM_AW'(((alu_res - 32'(ADDR_BASE)) >> 2) << 1);
  assign hi_addr = lo_addr | SRAM_AW'(1);

`ifdef MEM_ADDR_CHECK_EN
  logic [31:0] offset;
  assign offset = alu_res - 32'(ADDR_BASE);
  // Word index beyond the SRAM's half-word space shows up as any offset bit above SRAM_AW.
  assign fault  = (alu_res < 32'(ADDR_BASE)) || (alu_res[1:0] != 2'b00) ||
                  ((offset >> (SRAM_AW + 1)) != '0);
`else
  assign fault  = 1'b0;
`endif

  assign freeze = ((state == IDLE) && req) || (state == LO) || (state == HI);

  // Bus outputs are registered on state entry so the strobes never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      rd_word         <= '0;
      fault_q         <= 1'b0;
      sram.sram_addr  <= '0;
      sram.sram_wdata <= '0;
      sram.sram_we_n  <= 1'b1;
      sram.sram_oe_n  <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
      mem_err         <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (fault) begin
              state   <= DONE;
              fault_q <= 1'b1;
`ifdef MEM_ADDR_CHECK_EN
              mem_err <= 1'b1;
`endif
            end else begin
              state           <= LO;
              wait_cnt        <= 4'(WAIT_CYCLES - 1);
              sram.sram_addr  <= lo_addr;
              sram.sram_we_n  <= ~mem_w_en;
              sram.sram_oe_n  <= ~mem_r_en;
              sram.sram_wdata <= mem_w_en ? st_val[15:0] : '0;
            end
          end
        end
        LO: begin
          if (wait_cnt == '0) begin
            if (!sram.sram_oe_n) rd_word[15:0] <= sram.sram_rdata;
            state          <= HI;
            wait_cnt       <= 4'(WAIT_CYCLES - 1);
            sram.sram_addr <= hi_addr;
            if (!sram.sram_we_n) sram.sram_wdata <= st_val[31:16];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        HI: begin
          if (wait_cnt == '0) begin
            if (!sram.sram_oe_n) rd_word[31:16] <= sram.sram_rdata;
            state           <= DONE;
            sram.sram_addr  <= '0;
            sram.sram_wdata <= '0;
            sram.sram_we_n  <= 1'b1;
            sram.sram_oe_n  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB pipeline register; a frozen cycle inserts a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      writeBackEn <= 1'b0;
      Dest_wb     <= '0;
      Result_WB   <= '0;
    end else if (freeze) begin
      writeBackEn <= 1'b0;
    end else begin
      writeBackEn <= wb_en_in & ~(fault_q & mem_r_en);
      Dest_wb     <= dest;
      Result_WB   <= mem_r_en ? rd_word : alu_res;
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the ARM-style pipeline.
- Takes EX/MEM results and performs loads/stores against an external 16-bit SRAM, using two half-word transfers per 32-bit word.
- Stalls the pipeline through `freeze` while an access is in flight.
- Registers the write-back triple that drives the register file's write port (register file writes on the falling clock edge).

Parameters:
- `WAIT_CYCLES`, 2, cycles each half-word transfer is held on the SRAM bus (legal range 1..15).
- `ADDR_BASE`, 1024, byte address mapped to SRAM word 0.
- `SRAM_AW`, 18, SRAM half-word address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_en_in`  in  1  instruction writes back.
- `mem_r_en`  in  1  load request.
- `mem_w_en`  in  1  store request (never asserted together with `mem_r_en`).
- `alu_res`  in  32  ALU result / effective byte address.
- `st_val`  in  32  store data.
- `dest`  in  4  destination register index.
- `freeze`  out  1  stall request to all upstream pipeline registers and the PC.
- `sram_addr`  out  `SRAM_AW`  half-word address.
- `sram_wdata`  out  16  write data.
- `sram_rdata`  in  16  read data, valid while `sram_oe_n`=0.
- `sram_we_n`  out  1  write strobe, active low.
- `sram_oe_n`  out  1  output enable, active low.
- `writeBackEn`  out  1  registered write enable to the register file.
- `Dest_wb`  out  4  registered destination index.
- `Result_WB`  out  32  registered write-back value.

Behaviour:
- **Reset:** `rst` asynchronous, active high. Outputs: state=IDLE, `freeze`=0, `sram_we_n`=1, `sram_oe_n`=1, `sram_addr`=0, `sram_wdata`=0, `writeBackEn`=0, `Dest_wb`=0, `Result_WB`=0. The wait counter and read-data latch clear to 0. A reset asserted mid-access abandons the access (a partially written word is permitted in SRAM) and returns to IDLE.
- **Address mapping:** `word` = (`alu_res` − `ADDR_BASE`) >> 2, truncated. Low half at {`word`,0}, high half at {`word`,1}, both truncated to `SRAM_AW` bits.
- **FSM states:** IDLE, LO, HI, DONE.
  - IDLE: if `mem_r_en` or `mem_w_en`, go to LO; `freeze`=1 combinationally in this cycle. Otherwise stay in IDLE with `freeze`=0.
  - LO: `sram_addr`=low half address. For reads `sram_oe_n`=0; for writes `sram_we_n`=0 and `sram_wdata`=`st_val`[15:0]. Held for exactly `WAIT_CYCLES` cycles, counted by the wait counter (reloaded on every state entry). On the last cycle, latch `sram_rdata` into read[15:0] (reads only), then go to HI.
  - HI: same as LO using the high address and `st_val`[31:16]. On the last cycle, latch read[31:16], then go to DONE.
  - DONE: `freeze`=0, strobes inactive. Go to IDLE unconditionally. The request is still present in this cycle but must not restart an access.
- **`freeze`:** asserted in IDLE-with-request, LO and HI, i.e. 1+2×`WAIT_CYCLES` consecutive cycles per memory instruction. It is combinational from state and request.
- **Strobes outside LO/HI:** `sram_we_n`=`sram_oe_n`=1. Both strobes are registered-state decoded and glitch-free.
- **MEM/WB register (rising edge):**
  - `freeze`=0: `writeBackEn`<=`wb_en_in`, `Dest_wb`<=`dest`, `Result_WB`<= (`mem_r_en` ? assembled read word : `alu_res`).
  - `freeze`=1: `writeBackEn`<=0 (bubble); `Dest_wb` and `Result_WB` hold.
  - A store with `wb_en_in`=0 produces no write-back.
- **Latency:** non-memory instruction reaches `writeBackEn` 1 cycle after being presented. A load or store takes 2+2×`WAIT_CYCLES` cycles (6 at the default).
- **Back-to-back requests:** two memory instructions in sequence both wait in full; there is exactly one DONE cycle between them.

Optional Feature:
- Macro `MEM_ADDR_CHECK_EN`.
- **Defined:** adds output `mem_err` (1 bit, reset 0, sticky until `rst`). A request in IDLE is faulting if `alu_res` < `ADDR_BASE`, or `alu_res`[1:0]≠0, or the word address exceeds 2^(`SRAM_AW`−1)−1. A faulting request:
  - skips LO/HI and goes straight to DONE; `freeze` is 1 for that single IDLE cycle;
  - issues no SRAM strobes;
  - for a load, forces `writeBackEn` to 0 on capture;
  - sets `mem_err`.
- **Undefined:** no `mem_err` port; no checks; the address is truncated as described in Behaviour.

Test Plan:
1. **Reset mid-access:** assert `rst` during a LO write → `sram_we_n`=1 immediately, `freeze`=0, FSM in IDLE, `writeBackEn`=0.
2. **ALU pass-through:** `wb_en_in`=1, `dest`=5, `alu_res`=0x1234, no mem → next edge `writeBackEn`=1, `Dest_wb`=5, `Result_WB`=0x1234; `freeze` never asserted.
3. **Store timing:** store `st_val`=0xDEADBEEF to `alu_res`=1028, `WAIT_CYCLES`=2 →
   - `freeze` high for 5 cycles;
   - `sram_addr`=2 with `sram_wdata`=0xBEEF, `sram_we_n`=0 for 2 cycles;
   - then `sram_addr`=3 with `sram_wdata`=0xDEAD for 2 cycles;
   - `writeBackEn` stays 0.
4. **Load:** load from 1028 after test 3, `dest`=7 → `Result_WB`=0xDEADBEEF, `Dest_wb`=7, `writeBackEn`=1 exactly 6 cycles after the request. `writeBackEn`=0 during the frozen cycles.
5. **Back-to-back loads:** two consecutive loads → two separate 5-cycle freezes separated by one DONE cycle, and exactly two `writeBackEn` pulses.
6. **`MEM_ADDR_CHECK_EN` defined:** load from 1026 → no SRAM strobes, 1-cycle freeze, `writeBackEn`=0, `mem_err`=1 and it stays 1 after a subsequent valid load.
